// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the in-order pipeline: a shifting scoreboard of in-flight
// destinations drives the interlock, EX forward selects, redirect flush and counters.

module pipeline_hazard_src #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int FWD_EN   = 1,
  parameter int LOAD_LAT = 2,
  parameter int FSEL_W   = 2
) (
  input  logic [REG_AW-1:0]            src,
  input  logic                         used,
  input  logic [DEPTH-1:0]             sb_v,
  input  logic [DEPTH-1:0]             sb_wr,
  input  logic [DEPTH-1:0]             sb_ld,
  input  logic [DEPTH-1:0][REG_AW-1:0] sb_rd,
  output logic                         haz,
  output logic [FSEL_W-1:0]            fsel
);
  logic hit, hit_ld;
  int   hit_idx;

  always_comb begin
    hit = 1'b0;
    hit_ld = 1'b0;
    hit_idx = 0;
    // scan oldest to youngest so the youngest producer is the one kept
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (used && src != '0 && sb_v[i] && sb_wr[i] && sb_rd[i] == src) begin
        hit = 1'b1;
        hit_ld = sb_ld[i];
        hit_idx = i;
      end
    end
    haz = 1'b0;
    fsel = '0;
    if (hit && hit_idx < DEPTH-1) begin
      if (FWD_EN == 0 || (hit_ld && hit_idx < LOAD_LAT-1)) haz = 1'b1;
      else fsel = FSEL_W'(hit_idx + 1);
    end
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 3,
  parameter int FWD_EN       = 1,
  parameter int LOAD_LAT     = 2,
  parameter int REDIRECT_STG = 1,
  parameter int CNT_W        = 16,
  parameter int FSEL_W       = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              redirect,
  output logic              en_IF,
  output logic              en_IFID,
  output logic              nop_IFID,
  output logic              nop_IDEX,
  output logic [FSEL_W-1:0] fwd_rs1_EX,
  output logic [FSEL_W-1:0] fwd_rs2_EX,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              busy
);
  logic [DEPTH-1:0]             v_q, v_d, wr_q, wr_d, ld_q, ld_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [FSEL_W-1:0]            fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [1:0][REG_AW-1:0]       src;
  logic [1:0]                   src_used, haz;
  logic [1:0][FSEL_W-1:0]       fsel;
  logic                         stall;

  assign src      = {id_rs2, id_rs1};
  assign src_used = {id_rs2_used, id_rs1_used};

  for (genvar s = 0; s < 2; s++) begin : g_src
    pipeline_hazard_src #(
      .REG_AW(REG_AW), .DEPTH(DEPTH), .FWD_EN(FWD_EN),
      .LOAD_LAT(LOAD_LAT), .FSEL_W(FSEL_W)
    ) u_src (
      .src(src[s]), .used(src_used[s]),
      .sb_v(v_q), .sb_wr(wr_q), .sb_ld(ld_q), .sb_rd(rd_q),
      .haz(haz[s]), .fsel(fsel[s])
    );
  end

  assign stall = id_valid && (|haz) && !redirect;

  always_comb begin
    en_IF = 1'b1;
    en_IFID = 1'b1;
    nop_IFID = 1'b0;
    nop_IDEX = 1'b0;
    if (!rst || redirect) begin
      nop_IFID = 1'b1;
      nop_IDEX = 1'b1;
    end else if (stall) begin
      en_IF = 1'b0;
      en_IFID = 1'b0;
      nop_IDEX = 1'b1;
    end
  end

  always_comb begin
    v_d = v_q;
    wr_d = wr_q;
    ld_d = ld_q;
    rd_d = rd_q;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]  = v_q[i-1];
      wr_d[i] = wr_q[i-1];
      ld_d[i] = ld_q[i-1];
      rd_d[i] = rd_q[i-1];
    end
    v_d[0]  = id_valid && !stall && !redirect;
    wr_d[0] = id_regwrite && id_rd != '0;
    ld_d[0] = id_is_load;
    rd_d[0] = id_rd;
    // everything younger than the redirecting instruction is squashed
    if (redirect)
      for (int i = 0; i < DEPTH; i++)
        if (i <= REDIRECT_STG) v_d[i] = 1'b0;
    fwd_rs1_d = v_d[0] ? fsel[0] : '0;
    fwd_rs2_d = v_d[0] ? fsel[1] : '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q))    stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q <= '0;
      wr_q <= '0;
      ld_q <= '0;
      rd_q <= '0;
      fwd_rs1_q <= '0;
      fwd_rs2_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q <= v_d;
      wr_q <= wr_d;
      ld_q <= ld_d;
      rd_q <= rd_d;
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_rs1_EX = fwd_rs1_q;
  assign fwd_rs2_EX = fwd_rs2_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign busy       = rst && (|v_q);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: forwarding, stall-only and narrow-counter/deep
// instances share one ID stream and are compared to an in-flight-instruction model.
module tb_pipeline_hazard_ctrl;
  localparam int NC = 3, MD = 21, LOAD_LAT = 2, RSTG = 1;

  logic clk = 1'b0, rst = 1'b0;
  logic id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic id_regwrite = 1'b0, id_is_load = 1'b0, redirect = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex, a_busy;
  logic b_en_if, b_en_ifid, b_nop_ifid, b_nop_idex, b_busy;
  logic c_en_if, c_en_ifid, c_nop_ifid, c_nop_idex, c_busy;
  logic [1:0] a_f1, a_f2, b_f1, b_f2;
  logic [4:0] c_f1, c_f2;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  logic [3:0] c_sc, c_fc;

  int nerr = 0, nchk = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FWD_EN(1)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
    .en_IF(a_en_if), .en_IFID(a_en_ifid), .nop_IFID(a_nop_ifid), .nop_IDEX(a_nop_idex),
    .fwd_rs1_EX(a_f1), .fwd_rs2_EX(a_f2), .stall_cnt(a_sc), .flush_cnt(a_fc), .busy(a_busy));

  pipeline_hazard_ctrl #(.FWD_EN(0)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
    .en_IF(b_en_if), .en_IFID(b_en_ifid), .nop_IFID(b_nop_ifid), .nop_IDEX(b_nop_idex),
    .fwd_rs1_EX(b_f1), .fwd_rs2_EX(b_f2), .stall_cnt(b_sc), .flush_cnt(b_fc), .busy(b_busy));

  pipeline_hazard_ctrl #(.FWD_EN(0), .DEPTH(21), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
    .en_IF(c_en_if), .en_IFID(c_en_ifid), .nop_IFID(c_nop_ifid), .nop_IDEX(c_nop_idex),
    .fwd_rs1_EX(c_f1), .fwd_rs2_EX(c_f2), .stall_cnt(c_sc), .flush_cnt(c_fc), .busy(c_busy));

  // Model: each configuration keeps the in-flight instructions by position after ID.
  typedef struct { bit v; bit wr; bit ld; int rd; } ent_t;
  ent_t sb[NC][MD];
  int m_f1[NC], m_f2[NC], m_sc[NC], m_fc[NC];

  function automatic int depth_of(input int c); return (c == 2) ? 21 : 3; endfunction
  function automatic int fwd_of(input int c); return (c == 0) ? 1 : 0; endfunction
  function automatic int cmax(input int c); return (c == 2) ? 15 : 65535; endfunction

  function automatic void eval_src(input int c, input int src, input bit used,
                                   output bit haz, output int fsel);
    bit found = 0;
    haz = 0;
    fsel = 0;
    if (used && src != 0)
      for (int i = 0; i < depth_of(c); i++)
        if (!found && sb[c][i].v && sb[c][i].wr && sb[c][i].rd == src) begin
          found = 1;
          if (i < depth_of(c) - 1) begin
            if (fwd_of(c) == 0 || (sb[c][i].ld && i < LOAD_LAT - 1)) haz = 1;
            else fsel = i + 1;
          end
        end
  endfunction

  function automatic bit m_stall(input int c);
    bit h1, h2;
    int f1, f2;
    eval_src(c, int'(id_rs1), id_rs1_used, h1, f1);
    eval_src(c, int'(id_rs2), id_rs2_used, h2, f2);
    return id_valid && (h1 || h2) && !redirect;
  endfunction

  function automatic logic [4:0] exp_ctl(input int c);
    bit b = 0;
    for (int i = 0; i < depth_of(c); i++) if (sb[c][i].v) b = 1;
    if (!rst) return 5'b11110;
    if (redirect) return {4'b1111, b};
    if (m_stall(c)) return {4'b0001, b};
    return {4'b1100, b};
  endfunction

  function automatic logic [127:0] exp_val(input int c);
    return {32'(m_f1[c]), 32'(m_f2[c]), 32'(m_sc[c]), 32'(m_fc[c])};
  endfunction

  function automatic logic [4:0] obs_ctl(input int c);
    case (c)
      0: return {a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex, a_busy};
      1: return {b_en_if, b_en_ifid, b_nop_ifid, b_nop_idex, b_busy};
      default: return {c_en_if, c_en_ifid, c_nop_ifid, c_nop_idex, c_busy};
    endcase
  endfunction

  function automatic logic [127:0] obs_val(input int c);
    case (c)
      0: return {32'(a_f1), 32'(a_f2), 32'(a_sc), 32'(a_fc)};
      1: return {32'(b_f1), 32'(b_f2), 32'(b_sc), 32'(b_fc)};
      default: return {32'(c_f1), 32'(c_f2), 32'(c_sc), 32'(c_fc)};
    endcase
  endfunction

  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      bit h1, h2, stl;
      int f1, f2;
      ent_t ne;
      if (!rst) begin
        for (int i = 0; i < MD; i++) sb[c][i] = '{0, 0, 0, 0};
        m_f1[c] = 0; m_f2[c] = 0; m_sc[c] = 0; m_fc[c] = 0;
      end else begin
        eval_src(c, int'(id_rs1), id_rs1_used, h1, f1);
        eval_src(c, int'(id_rs2), id_rs2_used, h2, f2);
        stl = id_valid && (h1 || h2) && !redirect;
        ne.v = id_valid && !stl && !redirect;
        ne.wr = id_regwrite && id_rd != 0;
        ne.ld = id_is_load;
        ne.rd = int'(id_rd);
        for (int i = depth_of(c) - 1; i > 0; i--) sb[c][i] = sb[c][i-1];
        sb[c][0] = ne;
        if (redirect) for (int i = 0; i <= RSTG; i++) sb[c][i].v = 0;
        m_f1[c] = ne.v ? f1 : 0;
        m_f2[c] = ne.v ? f2 : 0;
        if (stl && m_sc[c] < cmax(c)) m_sc[c]++;
        if (redirect && m_fc[c] < cmax(c)) m_fc[c]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit ld);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    id_rd = 5'(rd); id_regwrite = rw; id_is_load = ld;
  endtask

  task automatic do_reset();
    rst = 0; redirect = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; redirect = 0;
    set_id(1, 5, 1, 5, 1, 5, 1, 1);
    #2;
    if ({a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex, a_busy} !== 5'b11110) begin
      $display("FAIL reset_ctl got=%b exp=11110", {a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex, a_busy}); nerr++;
    end
    nchk++;
    tick(); tick();
    if ({a_f1, a_f2, a_sc, a_fc, a_busy} !== 37'd0) begin
      $display("FAIL reset_state got=%h exp=0", {a_f1, a_f2, a_sc, a_fc, a_busy}); nerr++;
    end
    nchk++;
    rst = 1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fwd_alu();
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);            // add x5,x1,x2
    tick();
    set_id(1, 5, 1, 3, 1, 6, 1, 0);            // sub x6,x5,x3
    #2;
    if ({a_en_if, a_nop_idex} !== 2'b10) begin
      $display("FAIL fwd_alu_nostall got=%b exp=10", {a_en_if, a_nop_idex}); nerr++;
    end
    nchk++;
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if ({a_f1, a_f2} !== 4'b0100 || a_sc !== 16'd0) begin
      $display("FAIL fwd_alu_sel got=%b/%0d exp=0100/0", {a_f1, a_f2}, a_sc); nerr++;
    end
    nchk++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);            // lw x5,0(x1)
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);            // add x6,x5,x5
    #2;
    if ({a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex} !== 4'b0001) begin
      $display("FAIL load_use_stall got=%b exp=0001", {a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex}); nerr++;
    end
    nchk++;
    tick();
    #2;
    if ({a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex} !== 4'b1100) begin
      $display("FAIL load_use_release got=%b exp=1100", {a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex}); nerr++;
    end
    nchk++;
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if ({a_f1, a_f2} !== 4'b1010 || a_sc !== 16'd1) begin
      $display("FAIL load_use_fwd got=%b/%0d exp=1010/1", {a_f1, a_f2}, a_sc); nerr++;
    end
    nchk++;
  endtask

  task automatic test_stall_only();
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);            // add x5
    tick();
    set_id(1, 5, 1, 3, 1, 6, 1, 0);            // sub x6,x5,x3
    for (int k = 0; k < 3; k++) begin
      #2;
      if (b_en_if !== (k >= 2) || {b_f1, b_f2} !== 4'b0000) begin
        $display("FAIL stall_only_cyc%0d got=%b/%b exp=%b/0000", k, b_en_if, {b_f1, b_f2}, k >= 2); nerr++;
      end
      nchk++;
      tick();
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if ({b_f1, b_f2} !== 4'b0000 || b_sc !== 16'd2) begin
      $display("FAIL stall_only_cnt got=%b/%0d exp=0000/2", {b_f1, b_f2}, b_sc); nerr++;
    end
    nchk++;
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1, 1, 1, 0, 0, 7, 1, 0);            // add x7 (ends up past the flush window)
    tick();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);            // lw x5
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);            // load-use reader, same cycle as redirect
    redirect = 1;
    #2;
    if ({a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex} !== 4'b1111) begin
      $display("FAIL redirect_ctl got=%b exp=1111", {a_en_if, a_en_ifid, a_nop_ifid, a_nop_idex}); nerr++;
    end
    nchk++;
    tick();
    redirect = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (a_busy !== 1'b1 || a_fc !== 16'd1 || a_sc !== 16'd0 || {a_f1, a_f2} !== 4'b0000) begin
      $display("FAIL redirect_cnt got=%b/%0d/%0d exp=1/1/0", a_busy, a_fc, a_sc); nerr++;
    end
    nchk++;
    tick();
    #2;
    if (a_busy !== 1'b0) begin
      $display("FAIL redirect_flushed got=%b exp=0", a_busy); nerr++;
    end
    nchk++;
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1, 1, 1, 0, 0, 0, 1, 0);            // addi x0,x1,..
    tick();
    set_id(1, 0, 1, 0, 1, 7, 1, 0);            // reader of x0
    #2;
    if ({a_en_if, b_en_if} !== 2'b11) begin
      $display("FAIL x0_nostall got=%b exp=11", {a_en_if, b_en_if}); nerr++;
    end
    nchk++;
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if ({a_f1, a_f2} !== 4'b0000) begin
      $display("FAIL x0_fwd got=%b exp=0000", {a_f1, a_f2}); nerr++;
    end
    nchk++;
  endtask

  task automatic test_cnt_sat();
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    repeat (20) tick();
    #2;
    if (c_sc !== 4'd15 || c_en_if !== 1'b1) begin
      $display("FAIL cnt_sat got=%0d/%b exp=15/1", c_sc, c_en_if); nerr++;
    end
    nchk++;
    rst = 0;
    tick();
    rst = 1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (c_sc !== 4'd0 || c_busy !== 1'b0) begin
      $display("FAIL cnt_reset got=%0d/%b exp=0/0", c_sc, c_busy); nerr++;
    end
    nchk++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      redirect = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 5) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      #2;
      for (int c = 0; c < NC; c++) begin
        if (obs_ctl(c) !== exp_ctl(c)) begin
          $display("FAIL rand_ctl dut%0d cyc%0d got=%b exp=%b", c, n, obs_ctl(c), exp_ctl(c)); nerr++;
        end
        nchk++;
        if (obs_val(c) !== exp_val(c)) begin
          $display("FAIL rand_val dut%0d cyc%0d got=%h exp=%h", c, n, obs_val(c), exp_val(c)); nerr++;
        end
        nchk++;
      end
      tick();
    end
    redirect = 0;
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_stall_only();
    test_redirect();
    test_x0();
    test_cnt_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the in-order RISC-V pipeline. It replaces the pure stall-based interlock with a registered scoreboard of in-flight destination registers, and adds a selectable forwarding mode, a load-use interlock, redirect flush and saturating performance counters. It sits beside the IF/ID/EX/Mem/WB stage logic. It drives the IF and IF/ID enables, the IF/ID and ID/EX NOP inserts, and the EX-stage operand-forward selects.

## Interface
- REG_AW, 5, register address width
- DEPTH, 3, number of post-ID stages tracked; entry 0 = EX, entry DEPTH-1 = WB
- FWD_EN, 1, 1 = forwarding mode, 0 = stall-only mode
- LOAD_LAT, 2, a load result is forwardable once its entry index is >= LOAD_LAT-1
- REDIRECT_STG, 1, entry index of the instruction that asserts redirect (1 = Mem)
- CNT_W, 16, performance counter width
- FSEL_W, $clog2(DEPTH+1), forward-select width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW each  source addresses in ID
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rd  in  REG_AW  destination in ID
- id_regwrite  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- redirect  in  1  taken branch or jump resolved at entry REDIRECT_STG
- en_IF  out  1  PC register enable
- en_IFID  out  1  IF/ID enable
- nop_IFID  out  1  load a bubble into IF/ID
- nop_IDEX  out  1  load a bubble into ID/EX
- fwd_rs1_EX, fwd_rs2_EX  out  FSEL_W each  EX operand source: 0 = ID/EX register value; k = result held in the stage register k after EX (1 = EX/Mem)
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters
- busy  out  1  any scoreboard entry valid

## Operation
- Scoreboard holds DEPTH entries {v, rd, wr, ld}. It shifts every cycle: new[i] = old[i-1]. new[0] is the ID instruction, or a bubble (v=0) on stall, redirect or !id_valid.
- Source match: src used, src != 0, and there is an entry with v & wr & rd == src. Only the lowest matching index i (youngest producer) is considered.
- Entry DEPTH-1 (WB) never causes a hazard, because the register file is write-through.
- FWD_EN=0: stall if the match index i < DEPTH-1.
- FWD_EN=1: stall if the match entry has ld and i < LOAD_LAT-1. Otherwise the forward select is i+1 when i < DEPTH-1, and 0 when i = DEPTH-1.
- Stall (no redirect): en_IF=0, en_IFID=0, nop_IDEX=1, nop_IFID=0, and a bubble enters entry 0.
- Redirect has priority over stall: en_IF=1, en_IFID=1, nop_IFID=1, nop_IDEX=1. Entries new[0..REDIRECT_STG] become invalid and new[REDIRECT_STG+1] = old[REDIRECT_STG]. flush_cnt increments and stall_cnt does not.
- Idle (neither stall nor redirect): en_IF=en_IFID=1, nops 0.
- Counters saturate at all-ones and do not wrap.
- x0 is never a hazard source. An ID instruction with rd=0 is recorded with wr=0.

## Timing
- en_IF, en_IFID, nop_IFID, nop_IDEX and busy are combinational from the scoreboard state and the ID-stage inputs in the same cycle.
- fwd_rs*_EX are registered. They are computed in ID and presented in the cycle the instruction occupies EX. They are cleared to 0 when a bubble enters EX.
- Load-use (FWD_EN=1, LOAD_LAT=2) costs exactly 1 stall cycle. Stall-only mode costs DEPTH-1-i cycles.
- Reset (rst=0 at an edge): all entries invalid, fwd selects 0, counters 0. While rst=0: en_IF=en_IFID=1, nop_IFID=nop_IDEX=1, busy=0.
- Reset asserted mid-stall or mid-redirect aborts the operation. The first cycle after release is idle.

## Test plan
- FWD_EN=1 sequence: add x5,x1,x2 followed by sub x6,x5,x3. Required: no stall, fwd_rs1_EX=1 while sub is in EX, stall_cnt stays 0.
- FWD_EN=1 sequence: lw x5,0(x1) followed by add x6,x5,x5. Required: exactly 1 cycle of en_IF=0/nop_IDEX=1, then fwd_rs1_EX=fwd_rs2_EX=2, stall_cnt=1.
- FWD_EN=0 sequence: add x5 followed by sub x6,x5. Required: 2 stall cycles, fwd always 0, stall_cnt=2.
- redirect=1 in the same cycle that a load-use hazard exists in ID. Required: no stall; nop_IFID=nop_IDEX=1 and en_IF=1; entries 0..1 cleared; flush_cnt=1, stall_cnt=0.
- Instruction writing x0, followed by a reader of x0. Required: no stall, fwd 0.
- CNT_W=4, 20 consecutive stall cycles. Required: stall_cnt=15. Then rst=0 for one edge. Required: stall_cnt=0, busy=0.
